// File: rtl/m_store_buf.sv
// Four-entry store buffer: aligns sw/sh/sb into byte lanes, queues them
// for data memory in order, and flags pending-store hazards for loads.
module m_store_buf (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_data,
   input  logic [1:0]  in_op,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        align_err,
   output logic [2:0]  count,
   input  logic [31:0] chk_addr,
   output logic        chk_hit
);

   logic [29:0] addr_q [4];
   logic [31:0] data_q [4];
   logic [3:0]  be_q   [4];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic        aligned;
   logic [3:0]  be_n;
   logic [31:0] data_n;
   logic        enq;
   logic        deq;
   logic        bad;
   logic [1:0]  off;

   always_comb begin
      aligned = 1'b0;
      be_n    = 4'b0000;
      data_n  = 32'h0;
      unique case (1'b1)
         (in_op == 2'b00): begin
            aligned = (in_addr[1:0] == 2'b00);
            be_n    = 4'b1111;
            data_n  = in_data;
         end
         (in_op == 2'b01): begin
            aligned = !in_addr[0];
            be_n    = in_addr[1] ? 4'b1100 : 4'b0011;
            data_n  = in_addr[1] ? {in_data[15:0], 16'h0}
                                 : {16'h0, in_data[15:0]};
         end
         (in_op == 2'b10): begin
            aligned = 1'b1;
            be_n    = 4'b0001 << in_addr[1:0];
            data_n  = {24'h0, in_data[7:0]} << {in_addr[1:0], 3'b000};
         end
         default: aligned = 1'b0;
      endcase
   end

   // in_ready depends only on registered count, never on mem_ready
   assign in_ready  = (count != 3'd4);
   assign mem_valid = (count != 3'd0);
   assign enq       = in_valid && in_ready && aligned;
   assign bad       = in_valid && in_ready && !aligned;
   assign deq       = mem_valid && mem_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= 3'd0;
         wr_ptr    <= 2'd0;
         rd_ptr    <= 2'd0;
         align_err <= 1'b0;
      end else begin
         align_err <= bad;
         if (enq) wr_ptr <= wr_ptr + 2'd1;
         if (deq) rd_ptr <= rd_ptr + 2'd1;
         unique case ({enq, deq})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq && !reset) begin
         addr_q[wr_ptr] <= in_addr[31:2];
         data_q[wr_ptr] <= data_n;
         be_q[wr_ptr]   <= be_n;
      end
   end

   assign mem_addr  = mem_valid ? {addr_q[rd_ptr], 2'b00} : 32'h0;
   assign mem_wdata = mem_valid ? data_q[rd_ptr] : 32'h0;
   assign mem_be    = mem_valid ? be_q[rd_ptr] : 4'b0000;

   // slot i is occupied when its distance from the head is below count
   always_comb begin
      chk_hit = 1'b0;
      off     = 2'd0;
      for (int i = 0; i < 4; i++) begin
         off = 2'(i) - rd_ptr;
         if (({1'b0, off} < count) && (addr_q[i] == chk_addr[31:2]))
            chk_hit = 1'b1;
      end
   end

endmodule

// File: tb/tb_m_store_buf.sv
// Directed bench for m_store_buf: encoding table plus FIFO,
// back-pressure, hazard and reset sequences.
module tb_m_store_buf;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [1:0]  in_op;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        align_err;
   logic [2:0]  count;
   logic [31:0] chk_addr;
   logic        chk_hit;

   int checks = 0;
   int errors = 0;

   logic [31:0] qa [$];
   logic [31:0] qd [$];

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      logic        ok;
      logic [31:0] maddr;
      logic [3:0]  be;
      logic [31:0] wd;
   } vec_t;

   vec_t vt [11];

   m_store_buf dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .in_op     (in_op),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .align_err (align_err),
      .count     (count),
      .chk_addr  (chk_addr),
      .chk_hit   (chk_hit)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // one cycle of sw-only traffic checked against a queue model
   task automatic step();
      bit acc;
      bit dq;
      chk("count", 32'(count), 32'(qa.size()));
      chk("in_ready", 32'(in_ready), 32'(qa.size() != 4));
      chk("mem_valid", 32'(mem_valid), 32'(qa.size() != 0));
      if (qa.size() != 0) begin
         chk("head_addr", mem_addr, qa[0]);
         chk("head_data", mem_wdata, qd[0]);
         chk("head_be", 32'(mem_be), 32'hF);
      end
      acc = in_valid && (in_op == 2'b00) && (in_addr[1:0] == 2'b00)
            && (qa.size() != 4);
      dq  = mem_ready && (qa.size() != 0);
      tick();
      if (dq) begin
         void'(qa.pop_front());
         void'(qd.pop_front());
      end
      if (acc) begin
         qa.push_back(in_addr);
         qd.push_back(in_data);
      end
   endtask

   initial begin
      vt[0]  = '{2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1,
                 32'h0000_0100, 4'hF, 32'hDEAD_BEEF};
      vt[1]  = '{2'b00, 32'h0000_0102, 32'h1111_2222, 1'b0,
                 32'h0, 4'h0, 32'h0};
      vt[2]  = '{2'b01, 32'h0000_2002, 32'h1234_BEEF, 1'b1,
                 32'h0000_2000, 4'hC, 32'hBEEF_0000};
      vt[3]  = '{2'b01, 32'h0000_2000, 32'h1234_BEEF, 1'b1,
                 32'h0000_2000, 4'h3, 32'h0000_BEEF};
      vt[4]  = '{2'b01, 32'h0000_2001, 32'h1234_BEEF, 1'b0,
                 32'h0, 4'h0, 32'h0};
      vt[5]  = '{2'b10, 32'h0000_1003, 32'h0000_00A5, 1'b1,
                 32'h0000_1000, 4'h8, 32'hA500_0000};
      vt[6]  = '{2'b10, 32'h0000_1000, 32'h1234_56C3, 1'b1,
                 32'h0000_1000, 4'h1, 32'h0000_00C3};
      vt[7]  = '{2'b10, 32'h0000_1001, 32'h0000_0077, 1'b1,
                 32'h0000_1000, 4'h2, 32'h0000_7700};
      vt[8]  = '{2'b10, 32'hABCD_1002, 32'hFFFF_FF11, 1'b1,
                 32'hABCD_1000, 4'h4, 32'h0011_0000};
      vt[9]  = '{2'b11, 32'h0000_0000, 32'h5555_5555, 1'b0,
                 32'h0, 4'h0, 32'h0};
      vt[10] = '{2'b00, 32'h0000_2001, 32'h0BAD_0BAD, 1'b0,
                 32'h0, 4'h0, 32'h0};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_addr   = 32'h0;
      in_data   = 32'h0;
      in_op     = 2'b00;
      mem_ready = 1'b1;
      chk_addr  = 32'h0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_mem_valid", 32'(mem_valid), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_be", 32'(mem_be), 32'h0);
      chk("rst_chk_hit", 32'(chk_hit), 32'h0);
      chk("rst_align_err", 32'(align_err), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);

      // encoding table, one request at a time with memory ready
      for (int i = 0; i < 11; i++) begin
         in_op    = vt[i].op;
         in_addr  = vt[i].addr;
         in_data  = vt[i].data;
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         chk($sformatf("v%0d_mem_valid", i), 32'(mem_valid), 32'(vt[i].ok));
         chk($sformatf("v%0d_align_err", i), 32'(align_err), 32'(!vt[i].ok));
         chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].ok));
         chk($sformatf("v%0d_addr", i), mem_addr, vt[i].maddr);
         chk($sformatf("v%0d_be", i), 32'(mem_be), 32'(vt[i].be));
         chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].wd);
         tick();
         chk($sformatf("v%0d_err_clear", i), 32'(align_err), 32'h0);
         chk($sformatf("v%0d_drained", i), 32'(mem_valid), 32'h0);
      end

      // misaligned request behind a pending entry
      mem_ready = 1'b0;
      in_op     = 2'b01;
      in_addr   = 32'h0000_2002;
      in_data   = 32'h1234_BEEF;
      in_valid  = 1'b1;
      tick();
      in_op   = 2'b00;
      in_addr = 32'h0000_2001;
      tick();
      in_valid = 1'b0;
      chk("mis_align_err", 32'(align_err), 32'h1);
      chk("mis_count", 32'(count), 32'h1);
      chk("mis_head_addr", mem_addr, 32'h0000_2000);
      chk("mis_head_be", 32'(mem_be), 32'hC);
      chk("mis_head_wdata", mem_wdata, 32'hBEEF_0000);
      tick();
      chk("mis_pulse_end", 32'(align_err), 32'h0);
      chk("mis_hold_count", 32'(count), 32'h1);
      chk("mis_hold_addr", mem_addr, 32'h0000_2000);
      mem_ready = 1'b1;
      tick();
      chk("mis_drain", 32'(count), 32'h0);

      // fill to four, hold off the fifth, then drain
      in_op     = 2'b00;
      mem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_addr  = 32'h400 + 32'(4 * k);
         in_data  = 32'hA0 + 32'(k);
         step();
      end
      in_addr = 32'h411;
      in_data = 32'hEE;
      step();
      chk("full_no_flag", 32'(align_err), 32'h0);
      chk_addr = 32'h40C;
      #1;
      chk("full_hit_tail", 32'(chk_hit), 32'h1);
      in_addr = 32'h410;
      in_data = 32'hA4;
      step();
      chk("full_held", 32'(count), 32'h4);
      mem_ready = 1'b1;
      step();
      chk_addr = 32'h400;
      #1;
      chk("popped_no_hit", 32'(chk_hit), 32'h0);
      chk_addr = 32'h40C;
      #1;
      chk("tail_still_hit", 32'(chk_hit), 32'h1);
      step();
      in_valid = 1'b0;
      repeat (5) step();
      chk("fifo_empty", 32'(count), 32'h0);

      // steady state at two entries with simultaneous enq/deq and wrap
      mem_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         in_addr  = 32'h800 + 32'(4 * k);
         in_data  = 32'hC000 + 32'(k);
         step();
      end
      mem_ready = 1'b1;
      for (int k = 2; k < 14; k++) begin
         in_addr = 32'h800 + 32'(4 * k);
         in_data = 32'hC000 + 32'(k);
         step();
         chk("steady_count", 32'(count), 32'h2);
      end
      in_valid = 1'b0;
      repeat (3) step();

      // load hazard check
      mem_ready = 1'b0;
      in_valid  = 1'b1;
      in_addr   = 32'h3000;
      in_data   = 32'h33;
      step();
      in_valid = 1'b0;
      chk_addr = 32'h3002;
      #1;
      chk("hz_hit", 32'(chk_hit), 32'h1);
      chk_addr = 32'h3004;
      #1;
      chk("hz_other_word", 32'(chk_hit), 32'h0);
      chk_addr = 32'h5000;
      in_addr  = 32'h5000;
      in_valid = 1'b1;
      #1;
      chk("hz_not_incoming", 32'(chk_hit), 32'h0);
      in_valid  = 1'b0;
      mem_ready = 1'b1;
      step();
      chk_addr = 32'h3002;
      #1;
      chk("hz_after_drain", 32'(chk_hit), 32'h0);

      // reset with three entries pending
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_addr  = 32'h700 + 32'(4 * k);
         in_data  = 32'h70 + 32'(k);
         step();
      end
      chk("pre_rst_count", 32'(count), 32'h3);
      reset   = 1'b1;
      in_addr = 32'h601;
      tick();
      chk("in_rst_no_err", 32'(align_err), 32'h0);
      in_addr = 32'h600;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      chk_addr = 32'h700;
      #1;
      chk("mid_rst_count", 32'(count), 32'h0);
      chk("mid_rst_valid", 32'(mem_valid), 32'h0);
      chk("mid_rst_addr", mem_addr, 32'h0);
      chk("mid_rst_be", 32'(mem_be), 32'h0);
      chk("mid_rst_hit", 32'(chk_hit), 32'h0);
      chk("mid_rst_err", 32'(align_err), 32'h0);
      qa.delete();
      qd.delete();
      mem_ready = 1'b1;
      repeat (4) begin
         tick();
         chk("no_write_after_rst", 32'(mem_valid), 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/m_store_buf.md
M_STORE_BUF -- requirements
Module: m_store_buf

Interface
REQ-001 clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  store request present.
REQ-004 in_ready  output  1  buffer can accept a request this cycle.
REQ-005 in_addr  input  32  byte address of the store.
REQ-006 in_data  input  32  register data, with the value in the low bits.
REQ-007 in_op  input  2  store width: 00 = sw, 01 = sh, 10 = sb, 11 = reserved.
REQ-008 mem_valid  output  1  head entry is presented to data memory.
REQ-009 mem_ready  input  1  data memory accepts the head entry this cycle.
REQ-010 mem_addr  output  32  word address of the head entry, {addr[31:2], 2'b00}.
REQ-011 mem_wdata  output  32  lane-aligned write data.
REQ-012 mem_be  output  4  byte enables; bit i enables bits [8i+7:8i].
REQ-013 align_err  output  1  one-cycle pulse: a misaligned or reserved request was dropped.
REQ-014 count  output  3  number of occupied entries, 0 to 4.
REQ-015 chk_addr  input  32  load address to check for a pending-store hazard.
REQ-016 chk_hit  output  1  an occupied entry has word address equal to chk_addr[31:2].

Function
REQ-017 The buffer SHALL be a 4-entry FIFO; each entry holds {word addr[31:2], wdata[31:0], be[3:0]}.
REQ-018 The read and write pointers SHALL be 2 bits wide and SHALL wrap from 3 to 0.
REQ-019 in_ready SHALL equal (count != 4); there is no same-cycle bypass when the buffer is full.
REQ-020 A request is accepted when in_valid && in_ready && aligned.
REQ-021 "aligned" SHALL be defined per op:
- sw: addr[1:0] == 00.
- sh: addr[0] == 0.
- sb: always aligned.
- op 11: never aligned.
REQ-022 Encoding for sw SHALL be be = 1111 and wdata = in_data.
REQ-023 Encoding for sh SHALL be:
- addr[1] == 0: be = 0011, wdata = {16'b0, in_data[15:0]}.
- addr[1] == 1: be = 1100, wdata = {in_data[15:0], 16'b0}.
REQ-024 Encoding for sb SHALL be be = 0001 << addr[1:0], with in_data[7:0] placed in lane addr[1:0] and all other lanes 0.
REQ-025 A request with in_valid && in_ready && !aligned SHALL NOT be enqueued.
REQ-026 For such a request, align_err SHALL be 1 in the following cycle only.
REQ-027 A request with in_valid && !in_ready SHALL be neither enqueued nor flagged, even if misaligned.
REQ-028 mem_valid SHALL equal (count != 0).
REQ-029 mem_addr, mem_wdata and mem_be SHALL be driven from the head entry's registers and SHALL be 0 when count == 0.
REQ-030 The head entry is dequeued on mem_valid && mem_ready.
REQ-031 While mem_valid && !mem_ready, the head outputs SHALL hold stable.
REQ-032 An accepted request SHALL appear on the mem port no earlier than the next cycle.
REQ-033 The mem port SHALL present entries in acceptance order.
REQ-034 count update rules:
- Enqueue and dequeue in the same cycle: count unchanged.
- Enqueue only: count + 1.
- Dequeue only: count - 1.
- Dequeue while count == 0 cannot occur.
REQ-035 chk_hit SHALL be combinational and SHALL be 1 iff some occupied entry's word address equals chk_addr[31:2].
REQ-036 chk_hit SHALL NOT include the request being enqueued in the current cycle.
REQ-037 The module SHALL contain no combinational path from mem_ready to in_ready.

Reset
REQ-038 On a clk edge with reset == 1, the block SHALL set count = 0, both pointers = 0 and align_err = 0.
REQ-039 In the cycle after reset, mem_valid, mem_addr, mem_wdata, mem_be and chk_hit SHALL all be 0.
REQ-040 A reset asserted mid-operation SHALL discard all pending entries without driving them to memory.
REQ-041 While reset == 1, no request SHALL be enqueued and no align_err SHALL be raised.

Verification
REQ-042 sb, addr 0x1003, data 0x000000A5, mem_ready = 1 -> next cycle: mem_addr 0x1000, be 1000, wdata 0xA5000000.
REQ-043 sh, addr 0x2002, data 0x1234BEEF -> be 1100, wdata 0xBEEF0000; then sw, addr 0x2001 -> not enqueued, align_err high for 1 cycle, count unchanged.
REQ-044 Five sw requests with mem_ready = 0 -> count reaches 4 and in_ready drops to 0; the fifth request is held off.
REQ-045 In REQ-044, release mem_ready -> the four entries drain in order, and the fifth is accepted once in_ready returns.
REQ-046 At count = 2, enqueue and dequeue in the same cycle -> count stays 2; pointer wrap verified over 10 or more entries.
REQ-047 Pending entry at word 0x3000, chk_addr 0x3002 -> chk_hit = 1; after that entry drains -> chk_hit = 0.
REQ-048 Reset asserted with 3 entries pending -> next cycle count = 0 and mem_valid = 0; no further memory writes occur.
